mcu_amux_bridge: RTL and testbench
==================================

// Module: mcu_amux_bridge
// PURPOSE
//  Parametrised successor of the MCU multiplexed-AD (FSMC NOR/PSRAM-style) bus bridge into the FPGA register/memory space.
//  Adds configurable sync depth and address width, burst auto-increment, a read strobe for side-effect registers,
//  optional registered read data and a sticky protocol-error flag.
//  Sits between MCU pins and the register file/DPRAM; one clock domain (clk).
// PARAMETERS
//  AW        17  byte-address width of wraddr/rdaddr (2..17); word address WA = AW-1 bits taken from ad[AW-2:0]
//  SYNC      2   synchroniser depth for all pin inputs (>=2); every input gets the same depth
//  BURST_EN  1   1: word address +1 after each completed write or read access within one ne cycle; 0: address fixed
//  RD_REG    0   0: ad driven from rddata combinationally; 1: ad driven from rd_hold register
//  RD_LAT    1   cycles from read pulse to valid rddata (0..3); used only when RD_REG=1
// PORTS
//  clk      in   1      system clock
//  aclr     in   1      reset, synchronous, active-high
//  ne       in   1      chip select, active-low, async to clk
//  noe      in   1      output enable, active-low
//  nwe      in   1      write enable, active-low
//  nadv     in   1      address valid, active-low
//  nbl      in   2      byte lanes, active-low
//  ad       inout 16    multiplexed address/data
//  wraddr   out  AW     byte write address {WA,1'b0}
//  rdaddr   out  AW     byte read address {WA,1'b0}
//  be       out  2      write byte enables (~nbl)
//  write    out  1      one-cycle write strobe
//  wrdata   out  16     write data
//  read     out  1      one-cycle read strobe (rdaddr valid)
//  rddata   in   16     read data from memory side
//  err      out  1      sticky protocol error
// BEHAVIOUR
//  - Inputs pass SYNC flops; internal cs/oe/we/adv = synced, inverted pins. ad tristate: driven when raw !ne && !noe (unsynced).
//  - Reset: state=IDLE, WA=0, wraddr/rdaddr=0, be=0, wrdata=0, write=0, read=0, err=0, rd_hold=0, sync chains=inactive.
//  - FSM states IDLE, ADDR, WR, RD:
//    IDLE: cs && adv -> ADDR, WA <= ad_s[AW-2:0]. cs without adv seen first (e.g. reset mid-access) stays IDLE: access ignored.
//    ADDR: adv re-latches WA each cycle; we -> WR; oe -> RD; !cs -> IDLE.
//    WR: each cycle capture wrdata<=ad_s, be<=~nbl_s. On we deassert (or !cs): write=1 one cycle, wraddr={WA,0};
//        next cycle WA<=WA+1 if BURST_EN (modulo 2^(AW-1), wraps silently); -> ADDR (or IDLE if !cs).
//    RD: on entry read=1 one cycle, rdaddr={WA,0}. On oe deassert: WA+1 if BURST_EN; -> ADDR (IDLE if !cs).
//  - rdaddr also follows WA continuously in ADDR so RD_REG=0 combinational reads see data before oe sync.
//  - RD_REG=1: rd_hold <= rddata every cycle except frozen from RD_LAT cycles after read until leaving RD.
//  - write and read never both high; write latency = SYNC+1 clk after nwe rise at pins.
//  - we && oe both active in ADDR/WR/RD: err<=1 (sticky until aclr); write takes priority, RD not entered.
//  - adv asserted while in WR or RD: err<=1, ignored.
//  - cs drop in any state -> IDLE next cycle; pending WR still commits exactly one write.
// STRUCTURE
//  - Package mcu_bus_pkg: typedef enum logic [1:0] {IDLE,ADDR,WR,RD} amux_state_t; constant AD_W=16.
//  - One sub-module: sync_chain #(W,DEPTH) (reset to given inactive value), instantiated for ctrl pins (reset '1) and ad.
//  - FSM, address counter, write/read strobes and rd_hold in this module.
// TESTING
//  - Single write: adv ad=0x0123, then nwe low ad=0xBEEF nbl=2'b00 -> one write, wraddr=0x0246, wrdata=0xBEEF, be=2'b11.
//  - Burst write BURST_EN=1: adv 0x7FFF then 3 nwe pulses -> writes at wraddr 0xFFFE,0x0000,0x0002 (wrap); BURST_EN=0 -> all 0xFFFE.
//  - Read: adv 0x0010, noe low, rddata=0xA5A5 -> read=1 once with rdaddr=0x0020, ad=0xA5A5 while noe low, Z after.
//  - RD_REG=1, RD_LAT=2: rddata changes to 0x1111 after latch window -> ad stays at value sampled 2 cycles after read.
//  - Conflict: noe and nwe low together -> err=1, write issued, no read; err stays 1 until aclr.
//  - aclr mid-write (nwe low) then release -> no write pulse for that access, next full access works normally.

Source files
------------

// File: rtl/mcu_bus_pkg.sv
// Shared types and constants for the MCU multiplexed-AD bus bridge.
package mcu_bus_pkg;

   typedef enum logic [1:0] {IDLE, ADDR, WR, RD} amux_state_t;

   localparam int unsigned AD_W   = 16;
   localparam int unsigned CTRL_W = 6;

endpackage

// File: rtl/sync_chain.sv
// Multi-stage input synchroniser; every stage resets to the given inactive value.
module sync_chain #(
   parameter int unsigned W              = 1,
   parameter int unsigned DEPTH          = 2,
   parameter logic [W-1:0] RST_VAL       = '0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_stage [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
      end else begin
         r_stage[0] <= i_d;
         for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/mcu_amux_bridge.sv
// MCU multiplexed address/data bus bridge into the FPGA register/memory space:
// synchronised pins, address latch with burst increment, write/read strobes, sticky error.
module mcu_amux_bridge
   import mcu_bus_pkg::*;
#(
   parameter int unsigned AW       = 17,
   parameter int unsigned SYNC     = 2,
   parameter int unsigned BURST_EN = 1,
   parameter int unsigned RD_REG   = 0,
   parameter int unsigned RD_LAT   = 1
) (
   input  logic            clk,
   input  logic            aclr,
   input  logic            ne,
   input  logic            noe,
   input  logic            nwe,
   input  logic            nadv,
   input  logic [1:0]      nbl,
   inout  wire  [AD_W-1:0] ad,
   output logic [AW-1:0]   wraddr,
   output logic [AW-1:0]   rdaddr,
   output logic [1:0]      be,
   output logic            write,
   output logic [AD_W-1:0] wrdata,
   output logic            read,
   input  logic [AD_W-1:0] rddata,
   output logic            err
);

   localparam int unsigned WAW     = AW - 1;
   localparam logic [2:0]  LAT_V   = 3'(RD_LAT);
   localparam logic        BURST_B = (BURST_EN != 0);

   logic [CTRL_W-1:0] w_ctrl_s;
   logic [AD_W-1:0]   w_ad_s;
   logic              w_cs, w_oe, w_we, w_adv;
   logic [1:0]        w_nbl_s;

   sync_chain #(.W(CTRL_W), .DEPTH(SYNC), .RST_VAL('1)) u_sync_ctrl (
      .i_clk (clk),
      .i_rst (aclr),
      .i_d   ({ne, noe, nwe, nadv, nbl}),
      .o_q   (w_ctrl_s)
   );

   sync_chain #(.W(AD_W), .DEPTH(SYNC), .RST_VAL('0)) u_sync_ad (
      .i_clk (clk),
      .i_rst (aclr),
      .i_d   (ad),
      .o_q   (w_ad_s)
   );

   assign w_cs    = ~w_ctrl_s[5];
   assign w_oe    = ~w_ctrl_s[4];
   assign w_we    = ~w_ctrl_s[3];
   assign w_adv   = ~w_ctrl_s[2];
   assign w_nbl_s = w_ctrl_s[1:0];

   amux_state_t    r_state, w_next;
   logic [WAW-1:0] r_wa, w_wa_cur;
   logic [AW-1:0]  r_wraddr, r_rdaddr;
   logic [1:0]     r_be;
   logic [AD_W-1:0] r_wrdata, r_rd_hold;
   logic           r_write, r_read, r_err;
   logic [2:0]     r_lat_cnt;
   logic           w_load_wa, w_inc_wa, w_wr_stb, w_rd_stb, w_set_err, w_capture;
   logic           w_hold_frz, w_ad_oe;
   logic [AD_W-1:0] w_rd_out;

   always_comb begin
      w_next    = r_state;
      w_load_wa = 1'b0;
      w_inc_wa  = 1'b0;
      w_wr_stb  = 1'b0;
      w_rd_stb  = 1'b0;
      w_set_err = 1'b0;
      w_capture = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_cs && w_adv) begin
               w_next    = ADDR;
               w_load_wa = 1'b1;
            end
         end
         ADDR: begin
            if (!w_cs) begin
               w_next = IDLE;
            end else begin
               w_load_wa = w_adv;
               w_set_err = w_we && w_oe;
               if (w_we) begin
                  w_next = WR;
               end else if (w_oe) begin
                  w_next   = RD;
                  w_rd_stb = 1'b1;
               end
            end
         end
         WR: begin
            w_set_err = w_adv || (w_we && w_oe);
            // A chip-select drop still commits the pending write exactly once.
            if (!w_cs || !w_we) begin
               w_wr_stb = 1'b1;
               w_inc_wa = BURST_B;
               w_next   = w_cs ? ADDR : IDLE;
            end else begin
               w_capture = 1'b1;
            end
         end
         RD: begin
            w_set_err = w_adv || (w_we && w_oe);
            if (!w_cs || !w_oe) begin
               w_inc_wa = BURST_B;
               w_next   = w_cs ? ADDR : IDLE;
            end else if (w_we) begin
               w_next = WR;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_wa_cur   = w_load_wa ? w_ad_s[WAW-1:0] : r_wa;
   // rd_hold freezes once the RD_LAT-th cycle after the read strobe has been sampled.
   assign w_hold_frz = (r_state == RD) && (r_lat_cnt > LAT_V);

   always_ff @(posedge clk) begin
      if (aclr) begin
         r_state   <= IDLE;
         r_wa      <= '0;
         r_wraddr  <= '0;
         r_rdaddr  <= '0;
         r_be      <= '0;
         r_wrdata  <= '0;
         r_write   <= 1'b0;
         r_read    <= 1'b0;
         r_err     <= 1'b0;
         r_rd_hold <= '0;
         r_lat_cnt <= '0;
      end else begin
         r_state <= w_next;
         r_write <= w_wr_stb;
         r_read  <= w_rd_stb;
         if (w_load_wa)      r_wa <= w_ad_s[WAW-1:0];
         else if (w_inc_wa)  r_wa <= r_wa + WAW'(1);
         if (w_wr_stb)       r_wraddr <= {r_wa, 1'b0};
         if (w_load_wa || r_state == ADDR) r_rdaddr <= {w_wa_cur, 1'b0};
         if (w_capture) begin
            r_wrdata <= w_ad_s;
            r_be     <= ~w_nbl_s;
         end
         if (w_set_err)      r_err <= 1'b1;
         if (w_rd_stb)       r_lat_cnt <= '0;
         else if (r_state == RD && r_lat_cnt <= LAT_V) r_lat_cnt <= r_lat_cnt + 3'd1;
         if (!w_hold_frz)    r_rd_hold <= rddata;
      end
   end

   assign w_ad_oe  = !ne && !noe;
   assign w_rd_out = (RD_REG != 0) ? r_rd_hold : rddata;
   assign ad       = w_ad_oe ? w_rd_out : 'z;

   assign wraddr = r_wraddr;
   assign rdaddr = r_rdaddr;
   assign be     = r_be;
   assign write  = r_write;
   assign wrdata = r_wrdata;
   assign read   = r_read;
   assign err    = r_err;

endmodule

// File: tb/tb_mcu_amux_bridge.sv
// Directed bench: three bridge instances (burst, fixed address, registered read) share the MCU pins.
module tb_mcu_amux_bridge;

   logic        clk = 1'b0;
   logic        aclr, ne, noe, nwe, nadv;
   logic [1:0]  nbl;
   logic [15:0] rddata, tb_ad;
   logic        tb_ad_en;

   wire  [15:0] ad0, ad1, ad2;
   logic [15:0] wraddr0, rdaddr0, wrdata0, wraddr1, rdaddr1, wrdata1, wraddr2, rdaddr2, wrdata2;
   logic [1:0]  be0, be1, be2;
   logic        write0, read0, err0, write1, read1, err1, write2, read2, err2;

   int n_cmp = 0;
   int n_err = 0;
   int n_both = 0;

   logic [15:0] q0_wa[$], q0_wd[$], q1_wa[$], q0_ra[$];
   logic [1:0]  q0_be[$];

   always #5 clk = ~clk;

   assign ad0 = tb_ad_en ? tb_ad : 16'bz;
   assign ad1 = tb_ad_en ? tb_ad : 16'bz;
   assign ad2 = tb_ad_en ? tb_ad : 16'bz;

   mcu_amux_bridge #(.AW(16), .SYNC(2), .BURST_EN(1), .RD_REG(0), .RD_LAT(1)) u0 (
      .clk(clk), .aclr(aclr), .ne(ne), .noe(noe), .nwe(nwe), .nadv(nadv), .nbl(nbl), .ad(ad0),
      .wraddr(wraddr0), .rdaddr(rdaddr0), .be(be0), .write(write0), .wrdata(wrdata0),
      .read(read0), .rddata(rddata), .err(err0)
   );

   mcu_amux_bridge #(.AW(16), .SYNC(2), .BURST_EN(0), .RD_REG(0), .RD_LAT(1)) u1 (
      .clk(clk), .aclr(aclr), .ne(ne), .noe(noe), .nwe(nwe), .nadv(nadv), .nbl(nbl), .ad(ad1),
      .wraddr(wraddr1), .rdaddr(rdaddr1), .be(be1), .write(write1), .wrdata(wrdata1),
      .read(read1), .rddata(rddata), .err(err1)
   );

   mcu_amux_bridge #(.AW(16), .SYNC(2), .BURST_EN(1), .RD_REG(1), .RD_LAT(2)) u2 (
      .clk(clk), .aclr(aclr), .ne(ne), .noe(noe), .nwe(nwe), .nadv(nadv), .nbl(nbl), .ad(ad2),
      .wraddr(wraddr2), .rdaddr(rdaddr2), .be(be2), .write(write2), .wrdata(wrdata2),
      .read(read2), .rddata(rddata), .err(err2)
   );

   always @(posedge clk) begin
      #1;
      if (write0) begin
         q0_wa.push_back(wraddr0);
         q0_wd.push_back(wrdata0);
         q0_be.push_back(be0);
      end
      if (write1) q1_wa.push_back(wraddr1);
      if (read0)  q0_ra.push_back(rdaddr0);
      if ((write0 && read0) || (write1 && read1) || (write2 && read2)) n_both++;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_q();
      q0_wa.delete(); q0_wd.delete(); q0_be.delete(); q1_wa.delete(); q0_ra.delete();
   endtask

   task automatic bus_addr(input logic [15:0] a);
      ne = 1'b0; nadv = 1'b0; tb_ad = a; tb_ad_en = 1'b1;
      cyc(2);
      nadv = 1'b1;
      cyc(1);
   endtask

   task automatic bus_wr(input logic [15:0] d, input logic [1:0] bl);
      tb_ad = d; tb_ad_en = 1'b1; nbl = bl; nwe = 1'b0;
      cyc(3);
      nwe = 1'b1;
      cyc(5);
   endtask

   task automatic bus_end();
      ne = 1'b1; nwe = 1'b1; noe = 1'b1; nadv = 1'b1; tb_ad_en = 1'b0; nbl = 2'b11;
      cyc(4);
   endtask

   task automatic test_reset();
      n_cmp++; if (write0 !== 1'b0)      begin n_err++; $display("FAIL reset_write got=%b exp=0", write0); end
      n_cmp++; if (read0 !== 1'b0)       begin n_err++; $display("FAIL reset_read got=%b exp=0", read0); end
      n_cmp++; if (err0 !== 1'b0)        begin n_err++; $display("FAIL reset_err got=%b exp=0", err0); end
      n_cmp++; if (wraddr0 !== 16'h0000) begin n_err++; $display("FAIL reset_wraddr got=%h exp=0000", wraddr0); end
      n_cmp++; if (rdaddr0 !== 16'h0000) begin n_err++; $display("FAIL reset_rdaddr got=%h exp=0000", rdaddr0); end
      n_cmp++; if (be0 !== 2'b00)        begin n_err++; $display("FAIL reset_be got=%b exp=00", be0); end
      n_cmp++; if (wrdata0 !== 16'h0000) begin n_err++; $display("FAIL reset_wrdata got=%h exp=0000", wrdata0); end
      n_cmp++; if (u0.w_ad_oe !== 1'b0)  begin n_err++; $display("FAIL reset_ad_oe got=%b exp=0", u0.w_ad_oe); end
   endtask

   task automatic test_single_write();
      int lat;
      clear_q();
      bus_addr(16'h0123);
      tb_ad = 16'hBEEF; nbl = 2'b00; nwe = 1'b0;
      cyc(3);
      nwe = 1'b1;
      lat = 0;
      for (int k = 1; k <= 8 && lat == 0; k++) begin
         @(negedge clk);
         if (write0) lat = k;
      end
      n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL wr_latency got=%0d exp=3", lat); end
      cyc(2);
      bus_end();
      n_cmp++; if (q0_wa.size() !== 1) begin n_err++; $display("FAIL wr_count got=%0d exp=1", q0_wa.size()); end
      if (q0_wa.size() > 0) begin
         n_cmp++; if (q0_wa[0] !== 16'h0246) begin n_err++; $display("FAIL wr_addr got=%h exp=0246", q0_wa[0]); end
         n_cmp++; if (q0_wd[0] !== 16'hBEEF) begin n_err++; $display("FAIL wr_data got=%h exp=BEEF", q0_wd[0]); end
         n_cmp++; if (q0_be[0] !== 2'b11)    begin n_err++; $display("FAIL wr_be got=%b exp=11", q0_be[0]); end
      end
   endtask

   task automatic test_burst_write();
      logic [15:0] exp0 [3];
      exp0[0] = 16'hFFFE; exp0[1] = 16'h0000; exp0[2] = 16'h0002;
      clear_q();
      bus_addr(16'h7FFF);
      bus_wr(16'h1111, 2'b00);
      bus_wr(16'h2222, 2'b00);
      bus_wr(16'h3333, 2'b00);
      bus_end();
      n_cmp++; if (q0_wa.size() !== 3) begin n_err++; $display("FAIL burst_count got=%0d exp=3", q0_wa.size()); end
      n_cmp++; if (q1_wa.size() !== 3) begin n_err++; $display("FAIL fixed_count got=%0d exp=3", q1_wa.size()); end
      for (int i = 0; i < 3; i++) begin
         if (i < q0_wa.size()) begin
            n_cmp++;
            if (q0_wa[i] !== exp0[i]) begin n_err++; $display("FAIL burst_addr[%0d] got=%h exp=%h", i, q0_wa[i], exp0[i]); end
         end
         if (i < q1_wa.size()) begin
            n_cmp++;
            if (q1_wa[i] !== 16'hFFFE) begin n_err++; $display("FAIL fixed_addr[%0d] got=%h exp=FFFE", i, q1_wa[i]); end
         end
      end
   endtask

   task automatic test_read();
      clear_q();
      rddata = 16'hA5A5;
      bus_addr(16'h0010);
      tb_ad_en = 1'b0; noe = 1'b0;
      cyc(1);
      n_cmp++; if (ad0 !== 16'hA5A5) begin n_err++; $display("FAIL rd_ad got=%h exp=A5A5", ad0); end
      cyc(5);
      noe = 1'b1;
      cyc(1);
      n_cmp++; if (u0.w_ad_oe !== 1'b0) begin n_err++; $display("FAIL rd_release got=%b exp=0", u0.w_ad_oe); end
      cyc(4);
      bus_end();
      n_cmp++; if (q0_ra.size() !== 1) begin n_err++; $display("FAIL rd_count got=%0d exp=1", q0_ra.size()); end
      if (q0_ra.size() > 0) begin
         n_cmp++; if (q0_ra[0] !== 16'h0020) begin n_err++; $display("FAIL rd_addr got=%h exp=0020", q0_ra[0]); end
      end
   endtask

   task automatic test_rd_reg();
      logic found;
      rddata = 16'h2222;
      bus_addr(16'h0040);
      tb_ad_en = 1'b0; noe = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 12 && !found; k++) begin
         @(negedge clk);
         if (read2) found = 1'b1;
      end
      n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL rdreg_strobe got=%b exp=1", found); end
      cyc(2);
      rddata = 16'h3333;
      cyc(1);
      rddata = 16'h1111;
      cyc(3);
      n_cmp++; if (ad2 !== 16'h3333) begin n_err++; $display("FAIL rdreg_hold got=%h exp=3333", ad2); end
      n_cmp++; if (ad0 !== 16'h1111) begin n_err++; $display("FAIL rdcomb_live got=%h exp=1111", ad0); end
      noe = 1'b1;
      cyc(4);
      bus_end();
   endtask

   task automatic test_conflict();
      clear_q();
      rddata = 16'h5A5A;
      bus_addr(16'h0005);
      tb_ad_en = 1'b0; nbl = 2'b00; noe = 1'b0; nwe = 1'b0;
      cyc(4);
      noe = 1'b1; nwe = 1'b1;
      cyc(5);
      bus_end();
      n_cmp++; if (err0 !== 1'b1)         begin n_err++; $display("FAIL conf_err got=%b exp=1", err0); end
      n_cmp++; if (q0_wa.size() !== 1)    begin n_err++; $display("FAIL conf_wcount got=%0d exp=1", q0_wa.size()); end
      n_cmp++; if (q0_ra.size() !== 0)    begin n_err++; $display("FAIL conf_rcount got=%0d exp=0", q0_ra.size()); end
      if (q0_wa.size() > 0) begin
         n_cmp++; if (q0_wa[0] !== 16'h000A) begin n_err++; $display("FAIL conf_addr got=%h exp=000A", q0_wa[0]); end
         n_cmp++; if (q0_wd[0] !== 16'h5A5A) begin n_err++; $display("FAIL conf_data got=%h exp=5A5A", q0_wd[0]); end
      end
      cyc(10);
      n_cmp++; if (err0 !== 1'b1) begin n_err++; $display("FAIL conf_sticky got=%b exp=1", err0); end
      aclr = 1'b1;
      cyc(2);
      aclr = 1'b0;
      cyc(2);
      n_cmp++; if (err0 !== 1'b0) begin n_err++; $display("FAIL conf_clear got=%b exp=0", err0); end
   endtask

   task automatic test_aclr_mid_write();
      clear_q();
      bus_addr(16'h0100);
      tb_ad = 16'hCAFE; nwe = 1'b0;
      cyc(4);
      aclr = 1'b1;
      cyc(2);
      aclr = 1'b0;
      cyc(4);
      nwe = 1'b1;
      cyc(6);
      bus_end();
      n_cmp++; if (q0_wa.size() !== 0) begin n_err++; $display("FAIL aclr_nowrite got=%0d exp=0", q0_wa.size()); end
      bus_addr(16'h0200);
      bus_wr(16'h0F0F, 2'b10);
      bus_end();
      n_cmp++; if (q0_wa.size() !== 1) begin n_err++; $display("FAIL aclr_next_count got=%0d exp=1", q0_wa.size()); end
      if (q0_wa.size() > 0) begin
         n_cmp++; if (q0_wa[0] !== 16'h0400) begin n_err++; $display("FAIL aclr_next_addr got=%h exp=0400", q0_wa[0]); end
         n_cmp++; if (q0_be[0] !== 2'b01)    begin n_err++; $display("FAIL aclr_next_be got=%b exp=01", q0_be[0]); end
         n_cmp++; if (q0_wd[0] !== 16'h0F0F) begin n_err++; $display("FAIL aclr_next_data got=%h exp=0F0F", q0_wd[0]); end
      end
   endtask

   task automatic test_no_overlap();
      n_cmp++; if (n_both !== 0) begin n_err++; $display("FAIL strobe_overlap got=%0d exp=0", n_both); end
   endtask

   initial begin
      aclr = 1'b1; ne = 1'b1; noe = 1'b1; nwe = 1'b1; nadv = 1'b1; nbl = 2'b11;
      rddata = 16'h0000; tb_ad = 16'h0000; tb_ad_en = 1'b0;
      cyc(4);
      test_reset();
      aclr = 1'b0;
      cyc(2);
      test_single_write();
      test_burst_write();
      test_read();
      test_rd_reg();
      test_conflict();
      test_aclr_mid_write();
      test_no_overlap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached=1 exp=0");
      $fatal(1, "bench did not finish");
   end

endmodule
